// File: rtl/riscv_multicycle.sv
// Multicycle RV32 subset core: one shared memory port, FETCH/DECODE/EXEC/MEM/WB sequencing.
// Illegal instructions park the core in HALT until reset.
module riscv_multicycle #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic                     halted,
    output logic                     retire
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_JAL, OP_ILL
    } op_t;

    state_t state, state_next;
    op_t op, dec_op;
    logic run;
    logic [31:0] ir;
    logic [DATA_WIDTH-1:0] pc, pc_old, rs1_val, rs2_val, imm, result, dec_imm, alu_out;
    logic [DATA_WIDTH-1:0] regs [32];
    logic mem_done, take_branch;

    // run is cleared by reset so the request stays low during the reset cycle itself
    assign mem_req   = run && (state == FETCH || state == MEM);
    assign mem_we    = mem_req && state == MEM && op == OP_SW;
    assign mem_addr  = (state == MEM) ? result[ADDRESS_WIDTH-1:0] : pc[ADDRESS_WIDTH-1:0];
    assign mem_wdata = rs2_val;
    assign mem_done  = mem_req && mem_ready;
    assign halted    = (state == HALT);
    assign a0        = regs[10];
    assign take_branch = (op == OP_BEQ && rs1_val == rs2_val) || (op == OP_BNE && rs1_val != rs2_val);

    always_comb begin
        dec_op  = OP_ILL;
        dec_imm = '0;
        case (ir[6:0])
            7'b0110011: begin
                if (ir[31:25] == 7'b0000000) begin
                    case (ir[14:12])
                        3'b000:  dec_op = OP_ADD;
                        3'b111:  dec_op = OP_AND;
                        3'b110:  dec_op = OP_OR;
                        3'b010:  dec_op = OP_SLT;
                        default: dec_op = OP_ILL;
                    endcase
                end else if (ir[31:25] == 7'b0100000 && ir[14:12] == 3'b000) begin
                    dec_op = OP_SUB;
                end
            end
            7'b0010011: if (ir[14:12] == 3'b000) begin
                dec_op  = OP_ADDI;
                dec_imm = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
            end
            7'b0000011: if (ir[14:12] == 3'b010) begin
                dec_op  = OP_LW;
                dec_imm = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
            end
            7'b0100011: if (ir[14:12] == 3'b010) begin
                dec_op  = OP_SW;
                dec_imm = {{(DATA_WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
            end
            7'b1100011: if (ir[14:13] == 2'b00) begin
                dec_op  = ir[12] ? OP_BNE : OP_BEQ;
                dec_imm = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            7'b1101111: begin
                dec_op  = OP_JAL;
                dec_imm = {{(DATA_WIDTH-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            default: dec_op = OP_ILL;
        endcase
    end

    always_comb begin
        alu_out = '0;
        case (op)
            OP_ADD:  alu_out = rs1_val + rs2_val;
            OP_SUB:  alu_out = rs1_val - rs2_val;
            OP_AND:  alu_out = rs1_val & rs2_val;
            OP_OR:   alu_out = rs1_val | rs2_val;
            OP_SLT:  alu_out = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
            OP_ADDI, OP_LW, OP_SW: alu_out = rs1_val + imm;
            OP_JAL:  alu_out = pc_old + DATA_WIDTH'(4);
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            FETCH:  if (mem_done) state_next = DECODE;
            DECODE: state_next = (dec_op == OP_ILL) ? HALT : EXEC;
            EXEC: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEM;
                    OP_BEQ, OP_BNE, OP_JAL: begin
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                    default: state_next = WB;
                endcase
            end
            MEM: if (mem_done) begin
                state_next = (op == OP_SW) ? FETCH : WB;
                retire     = (op == OP_SW);
            end
            WB: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
        // an instruction cut short by reset does not count as completed
        if (rst) retire = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            run     <= 1'b0;
            op      <= OP_ILL;
            ir      <= '0;
            pc      <= RESET_VECTOR;
            pc_old  <= '0;
            rs1_val <= '0;
            rs2_val <= '0;
            imm     <= '0;
            result  <= '0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
            case (state)
                FETCH: if (mem_done) begin
                    ir     <= mem_rdata[31:0];
                    pc_old <= pc;
                    pc     <= pc + DATA_WIDTH'(4);
                end
                DECODE: begin
                    op      <= dec_op;
                    rs1_val <= regs[ir[19:15]];
                    rs2_val <= regs[ir[24:20]];
                    imm     <= dec_imm;
                end
                EXEC: begin
                    result <= alu_out;
                    if (take_branch || op == OP_JAL) pc <= pc_old + imm;
                    if (op == OP_JAL && ir[11:7] != 5'd0) regs[ir[11:7]] <= alu_out;
                end
                MEM: if (mem_done && op == OP_LW) result <= mem_rdata;
                WB: if (ir[11:7] != 5'd0) regs[ir[11:7]] <= result;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/riscv_multicycle.md
RISCV_MULTICYCLE -- requirements
Module: riscv_multicycle

Interface
REQ-001 Parameter DATA_WIDTH, default 32: datapath, register and memory-data width.
REQ-002 Parameter ADDRESS_WIDTH, default 16: memory address width; PC is DATA_WIDTH, and mem_addr is its low ADDRESS_WIDTH bits.
REQ-003 Parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mem_req  output  1  memory access request, held until accepted.
REQ-007 mem_we  output  1  1 = store, 0 = load/fetch; valid while mem_req=1.
REQ-008 mem_addr  output  ADDRESS_WIDTH  byte address of access.
REQ-009 mem_wdata  output  DATA_WIDTH  store data.
REQ-010 mem_ready  input  1  access completes in the cycle where mem_req=1 and mem_ready=1.
REQ-011 mem_rdata  input  DATA_WIDTH  read data, valid in the completing cycle.
REQ-012 a0  output  DATA_WIDTH  live content of register x10.
REQ-013 halted  output  1  core stopped on illegal instruction.
REQ-014 retire  output  1  one-cycle pulse per completed instruction.

Function
REQ-015 Supported: add, sub, and, or, slt (R-type); addi, lw (I-type); sw; beq, bne; jal. Every other opcode/funct combination is illegal.
REQ-016 Register file: 32 x DATA_WIDTH; x0 reads 0, writes to x0 discarded.
REQ-017 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on handshake, latch IR, PC_old=PC, PC+=4, go DECODE; otherwise stay FETCH.
REQ-019 DECODE: latch rs1/rs2 values and sign-extended immediate; illegal -> HALT; else -> EXEC.
REQ-020 EXEC: ALU op; R/addi -> WB; lw/sw -> MEM with addr=rs1+imm; beq/bne: if taken PC=PC_old+imm, -> FETCH with retire=1; jal: rd=PC_old+4, PC=PC_old+imm, -> FETCH with retire=1.
REQ-021 MEM: mem_req=1, mem_we=1 for sw with mem_wdata=rs2; on handshake: sw -> FETCH with retire=1, lw latches mem_rdata -> WB.
REQ-022 WB: write rd, retire=1, -> FETCH.
REQ-023 mem_req, mem_we, mem_addr, mem_wdata SHALL be stable while mem_req=1 and mem_ready=0.
REQ-024 mem_req=0 in DECODE, EXEC, WB, HALT.
REQ-025 Latency with mem_ready tied 1: ALU/lw 4/5 cycles, sw 4, branch/jal 3.
REQ-026 Arithmetic modulo 2^DATA_WIDTH; slt signed; branch/jal offsets sign-extended, bit 0 zero.
REQ-027 mem_addr wraps modulo 2^ADDRESS_WIDTH; no alignment check.
REQ-028 HALT is absorbing until rst; halted=1 there; no register or memory writes.
REQ-029 Register write and read of same register in the same cycle: read returns old value.

Reset
REQ-030 With rst=1 at an edge: PC=RESET_VECTOR, state=FETCH, all registers 0, halted=0, retire=0, mem_req=0 for that cycle.
REQ-031 rst in any state, including mid-handshake, aborts the access with no register write; mem_req drops the cycle after.
REQ-032 First fetch request follows in the cycle after rst deasserts.

Verification
REQ-033 Program addi x10,x0,5; addi x10,x10,-7, ready tied 1 -> a0=0xFFFFFFFE after 8 cycles; two retire pulses.
REQ-034 sw x10,8(x0) then lw x11,8(x0), ready delayed 3 cycles each access -> mem_req/addr held stable; x11 equals stored value.
REQ-035 Sequence addi x10,x0,3 / addi x10,x10,-1 / bne x10,x0,-4 -> loop runs 3 times, a0=0, then fallthrough.
REQ-036 jal x1,+16 at PC=0x20 -> x1=0x24, next fetch address 0x30.
REQ-037 Illegal word 0x00000000 fetched -> halted=1 after DECODE; no further mem_req; rst -> fetch at RESET_VECTOR.
REQ-038 rst asserted during MEM stall of sw -> no write completes; next request is fetch at RESET_VECTOR.
